ascon_decrypt_top: RTL and testbench
====================================

# ascon_decrypt_top

Ascon-128 authenticated decryption engine, the receive-side counterpart of the encryption top. It takes key, nonce, a fixed number of pre-padded associated-data blocks and full 64-bit ciphertext blocks, and releases the corresponding plaintext block by block. It then recomputes the 128-bit tag and compares it with the received tag. It has its own control FSM, round counter, block counters and 320-bit state register, and performs one Ascon round per cycle using the team's combinational round function on `type_state`.

## Interface
- `AD_BLOCKS`, 1: number of 64-bit associated-data blocks. The caller supplies them already padded. Legal values are 1 or more.
- `CT_BLOCKS`, 3: number of full 64-bit ciphertext blocks. Legal values are 1 or more. The final padding block is applied internally.
- `clock_i` in 1: single clock, rising edge.
- `resetb_i` in 1: asynchronous, active-low reset.
- `start_i` in 1: start pulse. Sampled only in IDLE.
- `data_valid_i` in 1: `data_i` is valid. A transfer occurs when `data_valid_i` and `ready_o` are both high.
- `data_i` in 64: an AD block, then a ciphertext block, in stream order.
- `key_i` in 128: key. Must be held stable from `start_i` until `end_o`.
- `nonce_i` in 128: nonce. Sampled at start.
- `tag_i` in 128: received tag. Must be stable by the final round.
- `ready_o` out 1: high in WAIT_AD and WAIT_CT.
- `plain_o` out 64: recovered plaintext block.
- `plain_valid_o` out 1: one-cycle strobe qualifying `plain_o`.
- `tag_o` out 128: computed tag.
- `auth_ok_o` out 1: high when `tag_o` equals `tag_i`. Valid while `end_o` is high.
- `end_o` out 1: operation complete. Held until the next accepted start.

## Operation
- The state is x0..x4, with x0 in the MSBs. IV is 64'h80400C0600000000.
- Round constant for round r (0..11) is 8'hF0 − r·8'h0F. p12 uses r = 0..11; p6 uses r = 6..11. The 4-bit round counter is loaded with 0 or 6 and the permutation ends after round 11.
- FSM states: IDLE, INIT_PERM, WAIT_AD, AD_PERM, WAIT_CT, CT_PERM, FINAL_PERM.
- **IDLE**
  - On `start_i`: state ← IV‖K‖N, counter ← 0, clear `end_o` and `auth_ok_o`, clear block counters.
  - Go to INIT_PERM.
- **INIT_PERM**
  - Runs 12 rounds.
  - The round-11 writeback is XORed with 0^192‖K.
  - Go to WAIT_AD.
- **WAIT_AD**
  - On transfer: x0 ← x0 ⊕ `data_i`, counter ← 6.
  - Go to AD_PERM.
- **AD_PERM**
  - Runs 6 rounds.
  - If this is AD block `AD_BLOCKS`, the round-11 writeback also XORs 1 into x4 bit 0 (domain separation), then go to WAIT_CT.
  - Otherwise go to WAIT_AD.
- **WAIT_CT**
  - On transfer: `plain_o` ← x0 ⊕ `data_i`, `plain_valid_o` ← 1 for one cycle, x0 ← `data_i`, counter ← 6.
  - Go to CT_PERM.
- **CT_PERM**
  - Runs 6 rounds.
  - If this is CT block `CT_BLOCKS`, the round-11 writeback also does:
    - x0 ^= 64'h8000000000000000 (padding block);
    - x1 ^= K[127:64];
    - x2 ^= K[63:0];
    - counter ← 0;
    - go to FINAL_PERM.
  - Otherwise go to WAIT_CT.
- **FINAL_PERM**
  - Runs 12 rounds.
  - The round-11 edge registers `tag_o` ← (x3‖x4)_out ⊕ K and `auth_ok_o` ← (that value == `tag_i`), sets `end_o` ← 1, and returns to IDLE.
  - The tag compare is a full 128-bit equality with no early exit.
- Plaintext is released before authentication. The consumer must discard it when `auth_ok_o` = 0.

## Timing
- **Reset values:** every output is 0, the state register is 0, all counters are 0, FSM is in IDLE. Assertion mid-operation aborts immediately. After release the block waits for a new `start_i`.
- **`start_i`:** ignored outside IDLE. With `end_o` high, `start_i` in IDLE restarts and clears `end_o` on the same edge.
- **`data_valid_i`:** ignored when `ready_o` = 0. Data is never buffered.
- **Latency**, with start accepted at edge s:
  - init rounds run at edges s+1..s+12;
  - `ready_o` is high from s+12.
- **Latency**, for each block transfer at edge t:
  - permutation rounds run at edges t+1..t+6;
  - `ready_o` is low over t..t+6.
- **`plain_valid_o`:** high during the cycle after edge t.
- **End of operation:** for the last CT transfer at edge k, `end_o` rises at edge k+18.
- **Default parameters, `data_valid_i` held high:** `end_o` at s+52.

## Test plan
- **Round trip.** Inputs: key = nonce = 128'h000102030405060708090A0B0C0D0E0F, AD = 64'h3230323280000000, plaintext {64'h5A5A5A5A5A5A5A5A, 64'h0123456789ABCDEF, 64'hFFFFFFFF00000000}. Encrypt with the encryption top, then feed its ciphertext and tag to this block. Required: identical plaintext, `tag_o` equal to the encryptor's tag, `auth_ok_o` = 1, `end_o` at s+52.
- **Forged tag.** Same stimulus with `tag_i` bit 0 flipped. Required: identical plaintext, `tag_o` unchanged, `auth_ok_o` = 0, `end_o` = 1.
- **Gapped stream.** `data_valid_i` toggles randomly, including assertions during permutations. Required: same plaintext and tag; transfers occur only with `ready_o` high; `end_o` rises exactly 18 cycles after the last transfer.
- **Busy start.** Pulse `start_i` at s+5 and again during CT_PERM. Required: no effect, and results match the round-trip scenario.
- **Reset mid-op.** Drop `resetb_i` during CT_PERM of block 2, then restart. Required: all outputs read 0 while in reset, and a clean round-trip result after restart.
- **Back-to-back runs.** Run twice, changing the nonce to 128'h0F0E…00 for the second run. Required: `end_o` clears on the second start, and the second result matches the encryptor output for that nonce.

Source files
------------

// File: rtl/ascon_decrypt_top.sv
// Ascon-128 authenticated decryption: one permutation round per cycle, plaintext
// released per block, then recomputed tag compared against the received tag.
module ascon_decrypt_top #(
  parameter int AD_BLOCKS = 1,
  parameter int CT_BLOCKS = 3
) (
  input  logic         clock_i,
  input  logic         resetb_i,
  input  logic         start_i,
  input  logic         data_valid_i,
  input  logic [63:0]  data_i,
  input  logic [127:0] key_i,
  input  logic [127:0] nonce_i,
  input  logic [127:0] tag_i,
  output logic         ready_o,
  output logic [63:0]  plain_o,
  output logic         plain_valid_o,
  output logic [127:0] tag_o,
  output logic         auth_ok_o,
  output logic         end_o
);

  typedef struct packed {
    logic [63:0] x0;
    logic [63:0] x1;
    logic [63:0] x2;
    logic [63:0] x3;
    logic [63:0] x4;
  } type_state;

  typedef enum logic [2:0] {
    IDLE, INIT_PERM, WAIT_AD, AD_PERM, WAIT_CT, CT_PERM, FINAL_PERM
  } fsm_e;

  localparam logic [63:0] IV  = 64'h80400C0600000000;
  localparam logic [63:0] PAD = 64'h8000000000000000;
  localparam int ADW = (AD_BLOCKS > 1) ? $clog2(AD_BLOCKS) : 1;
  localparam int CTW = (CT_BLOCKS > 1) ? $clog2(CT_BLOCKS) : 1;

  function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // Round constant 8'hF0 - r*8'h0F reduces to {~r, r} for r in 0..11.
  function automatic type_state ascon_round(input type_state s, input logic [3:0] r);
    type_state t;
    logic [63:0] a0, a1, a2, a3, a4;
    logic [63:0] b0, b1, b2, b3, b4;
    a0 = s.x0 ^ s.x4;
    a1 = s.x1;
    a2 = s.x2 ^ {56'h0, ~r, r} ^ s.x1;
    a3 = s.x3;
    a4 = s.x4 ^ s.x3;
    b0 = a0 ^ (~a1 & a2);
    b1 = a1 ^ (~a2 & a3);
    b2 = a2 ^ (~a3 & a4);
    b3 = a3 ^ (~a4 & a0);
    b4 = a4 ^ (~a0 & a1);
    b1 = b1 ^ b0;
    b0 = b0 ^ b4;
    b3 = b3 ^ b2;
    b2 = ~b2;
    t.x0 = b0 ^ rotr(b0, 19) ^ rotr(b0, 28);
    t.x1 = b1 ^ rotr(b1, 61) ^ rotr(b1, 39);
    t.x2 = b2 ^ rotr(b2, 1)  ^ rotr(b2, 6);
    t.x3 = b3 ^ rotr(b3, 10) ^ rotr(b3, 17);
    t.x4 = b4 ^ rotr(b4, 7)  ^ rotr(b4, 41);
    return t;
  endfunction

  fsm_e            fsm_q;
  type_state       state_q, state_d;
  logic [3:0]      rnd_q;
  logic [ADW-1:0]  ad_cnt_q;
  logic [CTW-1:0]  ct_cnt_q;
  logic            ready_q, plain_valid_q, auth_q, end_q;
  logic [63:0]     plain_q;
  logic [127:0]    tag_q, tag_calc;
  logic            last_rnd;

  always_comb begin
    state_d  = ascon_round(state_q, rnd_q);
    tag_calc = {state_d.x3, state_d.x4} ^ key_i;
    last_rnd = (rnd_q == 4'd11);
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fsm_q         <= IDLE;
      state_q       <= '0;
      rnd_q         <= '0;
      ad_cnt_q      <= '0;
      ct_cnt_q      <= '0;
      ready_q       <= 1'b0;
      plain_valid_q <= 1'b0;
      plain_q       <= '0;
      tag_q         <= '0;
      auth_q        <= 1'b0;
      end_q         <= 1'b0;
    end else begin
      plain_valid_q <= 1'b0;
      case (fsm_q)
        IDLE: begin
          if (start_i) begin
            state_q  <= type_state'({IV, key_i, nonce_i});
            rnd_q    <= 4'd0;
            end_q    <= 1'b0;
            auth_q   <= 1'b0;
            ad_cnt_q <= '0;
            ct_cnt_q <= '0;
            fsm_q    <= INIT_PERM;
          end
        end
        INIT_PERM: begin
          rnd_q <= rnd_q + 4'd1;
          if (last_rnd) begin
            state_q <= type_state'(state_d ^ {192'h0, key_i});
            ready_q <= 1'b1;
            fsm_q   <= WAIT_AD;
          end else begin
            state_q <= state_d;
          end
        end
        WAIT_AD: begin
          if (data_valid_i) begin
            state_q.x0 <= state_q.x0 ^ data_i;
            rnd_q      <= 4'd6;
            ready_q    <= 1'b0;
            fsm_q      <= AD_PERM;
          end
        end
        AD_PERM: begin
          rnd_q <= rnd_q + 4'd1;
          if (last_rnd) begin
            ready_q <= 1'b1;
            if (ad_cnt_q == ADW'(AD_BLOCKS - 1)) begin
              // Domain separation between AD and message phases.
              state_q <= type_state'(state_d ^ 320'd1);
              fsm_q   <= WAIT_CT;
            end else begin
              state_q  <= state_d;
              ad_cnt_q <= ad_cnt_q + ADW'(1);
              fsm_q    <= WAIT_AD;
            end
          end else begin
            state_q <= state_d;
          end
        end
        WAIT_CT: begin
          if (data_valid_i) begin
            plain_q       <= state_q.x0 ^ data_i;
            plain_valid_q <= 1'b1;
            state_q.x0    <= data_i;
            rnd_q         <= 4'd6;
            ready_q       <= 1'b0;
            fsm_q         <= CT_PERM;
          end
        end
        CT_PERM: begin
          rnd_q <= rnd_q + 4'd1;
          if (last_rnd) begin
            if (ct_cnt_q == CTW'(CT_BLOCKS - 1)) begin
              // Empty padded final block plus key injection for finalisation.
              state_q <= type_state'(state_d ^ {PAD, key_i, 128'h0});
              rnd_q   <= 4'd0;
              fsm_q   <= FINAL_PERM;
            end else begin
              state_q  <= state_d;
              ct_cnt_q <= ct_cnt_q + CTW'(1);
              ready_q  <= 1'b1;
              fsm_q    <= WAIT_CT;
            end
          end else begin
            state_q <= state_d;
          end
        end
        FINAL_PERM: begin
          rnd_q   <= rnd_q + 4'd1;
          state_q <= state_d;
          if (last_rnd) begin
            tag_q  <= tag_calc;
            auth_q <= (tag_calc == tag_i);
            end_q  <= 1'b1;
            fsm_q  <= IDLE;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign ready_o       = ready_q;
  assign plain_o       = plain_q;
  assign plain_valid_o = plain_valid_q;
  assign tag_o         = tag_q;
  assign auth_ok_o     = auth_q;
  assign end_o         = end_q;

endmodule

// File: tb/tb_ascon_decrypt_top.sv
// Bench for ascon_decrypt_top: a reference Ascon-128 encryptor produces ciphertext
// and tag; the DUT must recover plaintext and re-derive the tag with exact timing.
module tb_ascon_decrypt_top;

  typedef logic [63:0] lane_t;

  typedef struct {
    logic [127:0]     key;
    logic [127:0]     nonce;
    lane_t            ad;
    logic [2:0][63:0] pt;
    bit               flip;
    int               mode;  // 0 streaming, 1 gapped, 2 busy start, 3 reset abort
    logic [2:0][63:0] ct;
    logic [127:0]     tag;
  } vec_t;

  typedef struct {
    lane_t pt;
    int    edge_no;
  } exp_t;

  localparam logic [127:0] K0 = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] N1 = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam int NV = 8;

  logic         clk = 1'b0;
  logic         resetb_i = 1'b0;
  logic         start_i = 1'b0;
  logic         data_valid_i = 1'b0;
  logic [63:0]  data_i = '0;
  logic [127:0] key_i = '0;
  logic [127:0] nonce_i = '0;
  logic [127:0] tag_i = '0;
  logic         ready_o;
  logic [63:0]  plain_o;
  logic         plain_valid_o;
  logic [127:0] tag_o;
  logic         auth_ok_o;
  logic         end_o;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   plain_seen = 0;
  exp_t exp_q[$];
  vec_t vecs[NV];

  ascon_decrypt_top dut (
    .clock_i      (clk),
    .resetb_i     (resetb_i),
    .start_i      (start_i),
    .data_valid_i (data_valid_i),
    .data_i       (data_i),
    .key_i        (key_i),
    .nonce_i      (nonce_i),
    .tag_i        (tag_i),
    .ready_o      (ready_o),
    .plain_o      (plain_o),
    .plain_valid_o(plain_valid_o),
    .tag_o        (tag_o),
    .auth_ok_o    (auth_ok_o),
    .end_o        (end_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: S-box as the published 5-bit lookup table, applied per bit column.
  function automatic logic [4:0] sbox(input logic [4:0] i);
    logic [4:0] o;
    case (i)
      5'd0:  o = 5'h04; 5'd1:  o = 5'h0b; 5'd2:  o = 5'h1f; 5'd3:  o = 5'h14;
      5'd4:  o = 5'h1a; 5'd5:  o = 5'h15; 5'd6:  o = 5'h09; 5'd7:  o = 5'h02;
      5'd8:  o = 5'h1b; 5'd9:  o = 5'h05; 5'd10: o = 5'h08; 5'd11: o = 5'h12;
      5'd12: o = 5'h1d; 5'd13: o = 5'h03; 5'd14: o = 5'h06; 5'd15: o = 5'h1c;
      5'd16: o = 5'h1e; 5'd17: o = 5'h13; 5'd18: o = 5'h07; 5'd19: o = 5'h0e;
      5'd20: o = 5'h00; 5'd21: o = 5'h0d; 5'd22: o = 5'h11; 5'd23: o = 5'h18;
      5'd24: o = 5'h10; 5'd25: o = 5'h0c; 5'd26: o = 5'h01; 5'd27: o = 5'h19;
      5'd28: o = 5'h16; 5'd29: o = 5'h0a; 5'd30: o = 5'h0f; default: o = 5'h17;
    endcase
    return o;
  endfunction

  function automatic lane_t ror(input lane_t v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [319:0] ref_perm(input logic [319:0] s, input int first);
    lane_t x[5];
    lane_t y[5];
    logic [4:0] col, o;
    logic [319:0] res;
    for (int k = 0; k < 5; k++) x[k] = s[319 - 64*k -: 64];
    for (int r = first; r < 12; r++) begin
      x[2] = x[2] ^ {56'h0, 8'(240 - 15*r)};
      for (int i = 0; i < 64; i++) begin
        col = {x[0][i], x[1][i], x[2][i], x[3][i], x[4][i]};
        o = sbox(col);
        for (int k = 0; k < 5; k++) y[k][i] = o[4-k];
      end
      x[0] = y[0] ^ ror(y[0], 19) ^ ror(y[0], 28);
      x[1] = y[1] ^ ror(y[1], 61) ^ ror(y[1], 39);
      x[2] = y[2] ^ ror(y[2], 1)  ^ ror(y[2], 6);
      x[3] = y[3] ^ ror(y[3], 10) ^ ror(y[3], 17);
      x[4] = y[4] ^ ror(y[4], 7)  ^ ror(y[4], 41);
    end
    for (int k = 0; k < 5; k++) res[319 - 64*k -: 64] = x[k];
    return res;
  endfunction

  task automatic ref_encrypt(inout vec_t v);
    logic [319:0] s;
    s = {64'h80400C0600000000, v.key, v.nonce};
    s = ref_perm(s, 0);
    s[127:0] = s[127:0] ^ v.key;
    s[319:256] = s[319:256] ^ v.ad;
    s = ref_perm(s, 6);
    s[0] = s[0] ^ 1'b1;
    for (int j = 0; j < 3; j++) begin
      s[319:256] = s[319:256] ^ v.pt[j];
      v.ct[j] = s[319:256];
      s = ref_perm(s, 6);
    end
    s[319:256] = s[319:256] ^ 64'h8000000000000000;
    s[255:128] = s[255:128] ^ v.key;
    s = ref_perm(s, 0);
    v.tag = s[127:0] ^ v.key;
  endtask

  always @(negedge clk) begin
    if (resetb_i && plain_valid_o) begin
      plain_seen++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL plain_extra: strobe with plain_o=%h but no block was sent", plain_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("plain_data", 128'(plain_o), 128'(e.pt));
        chk("plain_strobe_edge", 128'(cyc), 128'(e.edge_no));
      end
    end
  end

  task automatic run_op(input int vi);
    vec_t  tv;
    lane_t blocks[4];
    int    tr_edge[4];
    int    s_edge, nxt, budget, ct2_edge, wait_n;
    bit    r, valid, aborted;
    tv = vecs[vi];
    blocks[0] = tv.ad;
    for (int j = 0; j < 3; j++) blocks[j+1] = tv.ct[j];
    ct2_edge   = -1;
    aborted    = 1'b0;
    plain_seen = 0;

    @(negedge clk);
    key_i   = tv.key;
    nonce_i = tv.nonce;
    tag_i   = tv.tag ^ {127'h0, tv.flip};
    start_i = 1'b1;
    s_edge  = cyc + 1;
    @(negedge clk);
    start_i = 1'b0;
    chk("end_cleared_on_start", 128'(end_o), 128'(0));
    chk("auth_cleared_on_start", 128'(auth_ok_o), 128'(0));

    nxt = 0;
    budget = 0;
    while (nxt < 4 && budget < 400 && !aborted) begin
      r = ready_o;
      valid = (tv.mode == 1) ? ($urandom_range(0, 1) == 1) : 1'b1;
      data_valid_i = valid;
      data_i = blocks[nxt];
      start_i = (tv.mode == 2) &&
                ((cyc + 1 == s_edge + 5) || (ct2_edge > 0 && cyc + 1 == ct2_edge + 3));
      if (r && valid) begin
        tr_edge[nxt] = cyc + 1;
        if (nxt >= 1) exp_q.push_back('{pt: tv.pt[nxt-1], edge_no: cyc + 1});
        if (nxt == 2) ct2_edge = cyc + 1;
        nxt++;
      end
      @(negedge clk);
      budget++;
      if (tv.mode == 3 && ct2_edge > 0 && cyc == ct2_edge + 3) aborted = 1'b1;
    end
    data_valid_i = 1'b0;
    start_i = 1'b0;

    if (aborted) begin
      resetb_i = 1'b0;
      #1;
      chk("rst_ready", 128'(ready_o), 128'(0));
      chk("rst_plain", 128'(plain_o), 128'(0));
      chk("rst_plain_valid", 128'(plain_valid_o), 128'(0));
      chk("rst_tag", tag_o, 128'(0));
      chk("rst_auth", 128'(auth_ok_o), 128'(0));
      chk("rst_end", 128'(end_o), 128'(0));
      @(negedge clk);
      @(negedge clk);
      resetb_i = 1'b1;
      exp_q.delete();
      repeat (3) @(negedge clk);
      chk("post_rst_idle_ready", 128'(ready_o), 128'(0));
      chk("post_rst_idle_end", 128'(end_o), 128'(0));
      return;
    end

    if (nxt < 4) begin
      n_cmp++;
      n_bad++;
      $display("FAIL transfer_timeout: %0d of 4 blocks accepted", nxt);
      return;
    end

    wait_n = 0;
    while (!end_o && wait_n < 100) begin
      @(negedge clk);
      wait_n++;
    end
    if (!end_o) begin
      n_cmp++;
      n_bad++;
      $display("FAIL end_timeout: end_o=0 after %0d cycles, expected 1", wait_n);
      return;
    end
    chk("end_after_last_ct", 128'(cyc), 128'(tr_edge[3] + 18));
    if (tv.mode == 0 || tv.mode == 2) begin
      chk("first_transfer_edge", 128'(tr_edge[0]), 128'(s_edge + 13));
      chk("end_edge_from_start", 128'(cyc), 128'(s_edge + 52));
    end
    chk("tag_out", tag_o, tv.tag);
    chk("auth_ok", 128'(auth_ok_o), 128'(!tv.flip));
    chk("plain_count", 128'(plain_seen), 128'(3));
    @(negedge clk);
    chk("end_held", 128'(end_o), 128'(1));
  endtask

  initial begin
    for (int i = 0; i < NV; i++) begin
      vecs[i].key   = K0;
      vecs[i].nonce = K0;
      vecs[i].ad    = 64'h3230323280000000;
      vecs[i].pt    = {64'hFFFFFFFF00000000, 64'h0123456789ABCDEF, 64'h5A5A5A5A5A5A5A5A};
      vecs[i].flip  = 1'b0;
      vecs[i].mode  = 0;
    end
    vecs[1].flip  = 1'b1;
    vecs[2].mode  = 1;
    vecs[3].mode  = 2;
    vecs[4].mode  = 3;
    vecs[6].nonce = N1;
    vecs[7].mode  = 1;
    vecs[7].key   = {$urandom, $urandom, $urandom, $urandom};
    vecs[7].nonce = {$urandom, $urandom, $urandom, $urandom};
    vecs[7].ad    = {$urandom, $urandom};
    vecs[7].pt    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < NV; i++) ref_encrypt(vecs[i]);

    repeat (3) @(negedge clk);
    chk("reset_ready", 128'(ready_o), 128'(0));
    chk("reset_plain_valid", 128'(plain_valid_o), 128'(0));
    chk("reset_tag", tag_o, 128'(0));
    chk("reset_end", 128'(end_o), 128'(0));
    resetb_i = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < NV; i++) run_op(i);
    chk("queue_drained", 128'(exp_q.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
